// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman datapath stages.
// Provides operand widths, latency constants and the decrypt FSM state type.
package dh_pkg;

    localparam int unsigned P_W        = 32;
    localparam int unsigned D_W        = 64;
    localparam int unsigned IDX_W      = $clog2(P_W);
    localparam int unsigned MODMUL_LAT = P_W;
    localparam int unsigned DEC_LAT    = 2 + P_W * 2 * (P_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SQR,
        MUL,
        XOR,
        DONE
    } state_t;

endpackage

// File: rtl/dh_modmul.sv
// Interleaved shift-add modular multiplier: res = a * b mod p.
// Processes the multiplier b MSB first, one bit per cycle.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : sampled each edge; loads operands and processes bit P_W-1
//   a, b, p      : multiplicand, multiplier, modulus (a < p required)
//   done         : one-cycle pulse, res valid while high
//   res          : product modulo p
module dh_modmul
    import dh_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [P_W-1:0] a,
    input  logic [P_W-1:0] b,
    input  logic [P_W-1:0] p,
    output logic           done,
    output logic [P_W-1:0] res
);

    logic [P_W-1:0]   a_r;
    logic [P_W-1:0]   p_r;
    logic [P_W-1:0]   b_sh;
    logic [P_W-1:0]   r;
    logic [P_W-1:0]   r_next;
    logic [IDX_W-1:0] cnt;
    logic             run;

    // r < p and a < p, so 2r + a < 3p: two conditional subtractions
    // always bring the sum back below p, and P_W+2 bits never overflow.
    function automatic logic [P_W-1:0] mm_step(
        input logic [P_W-1:0] r_in,
        input logic           bit_in,
        input logic [P_W-1:0] a_in,
        input logic [P_W-1:0] p_in
    );
        logic [P_W+1:0] t;
        t = {1'b0, r_in, 1'b0} + (bit_in ? {2'b00, a_in} : '0);
        if (t >= {2'b00, p_in}) t = t - {2'b00, p_in};
        if (t >= {2'b00, p_in}) t = t - {2'b00, p_in};
        return t[P_W-1:0];
    endfunction

    // The start edge already consumes the first multiplier bit, so the
    // result lands P_W edges after start is sampled.
    assign r_next = start ? mm_step('0, b[P_W-1], a, p)
                          : mm_step(r, b_sh[P_W-1], a_r, p_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            p_r  <= '0;
            b_sh <= '0;
            r    <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            res  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r  <= a;
                p_r  <= p;
                b_sh <= {b[P_W-2:0], 1'b0};
                r    <= r_next;
                cnt  <= IDX_W'(MODMUL_LAT - 1);
                run  <= 1'b1;
            end else if (run) begin
                r    <= r_next;
                b_sh <= {b_sh[P_W-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
                if (cnt == IDX_W'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                    res  <= r_next;
                end
            end
        end
    end

endmodule

// File: rtl/decryption_r2.sv
// R2 decryption stage: k = pub^priv mod p (constant-time square-and-multiply),
// r2 = c1 ^ k.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   c1_valid_i  : start request (sampled in IDLE), also holds the result in DONE
//   c1          : received ciphertext
//   pub, priv, p: peer public value, own exponent, prime modulus
//   busy        : operation in progress
//   done_dec2   : result valid
//   err_o       : operand error (p < 2 or pub >= p), valid with done_dec2
//   k_o, r2_o   : shared key (zero-extended) and recovered plaintext
module decryption_r2
    import dh_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           c1_valid_i,
    input  logic [D_W-1:0] c1,
    input  logic [P_W-1:0] pub,
    input  logic [P_W-1:0] priv,
    input  logic [P_W-1:0] p,
    output logic           busy,
    output logic           done_dec2,
    output logic           err_o,
    output logic [D_W-1:0] k_o,
    output logic [D_W-1:0] r2_o
);

    state_t           state;
    logic [D_W-1:0]   c1_reg;
    logic [P_W-1:0]   pub_reg;
    logic [P_W-1:0]   priv_reg;
    logic [P_W-1:0]   p_reg;
    logic [P_W-1:0]   acc;
    logic [IDX_W-1:0] idx;
    logic             wait_mm;
    logic             err_flag;

    logic             mm_start;
    logic [P_W-1:0]   mm_a;
    logic [P_W-1:0]   mm_b;
    logic             mm_done;
    logic [P_W-1:0]   mm_res;

    // Each SQR/MUL step issues on its first cycle, then waits for done.
    always_comb begin
        mm_start = 1'b0;
        mm_a     = acc;
        mm_b     = acc;
        if ((state == SQR || state == MUL) && !wait_mm) begin
            mm_start = 1'b1;
        end
        if (state == MUL) begin
            mm_a = pub_reg;
        end
    end

    dh_modmul u_modmul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .p     (mm_p_unused_guard(p_reg)),
        .done  (mm_done),
        .res   (mm_res)
    );

    function automatic logic [P_W-1:0] mm_p_unused_guard(input logic [P_W-1:0] v);
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            c1_reg    <= '0;
            pub_reg   <= '0;
            priv_reg  <= '0;
            p_reg     <= '0;
            acc       <= '0;
            idx       <= '0;
            wait_mm   <= 1'b0;
            err_flag  <= 1'b0;
            busy      <= 1'b0;
            done_dec2 <= 1'b0;
            err_o     <= 1'b0;
            k_o       <= '0;
            r2_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c1_valid_i) begin
                        c1_reg   <= c1;
                        pub_reg  <= pub;
                        priv_reg <= priv;
                        p_reg    <= p;
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    // The error response is posted by the XOR stage so that
                    // both paths share one output write and done lands on cycle 2.
                    if (p_reg < P_W'(2) || pub_reg >= p_reg) begin
                        err_flag <= 1'b1;
                        state    <= XOR;
                    end else begin
                        err_flag <= 1'b0;
                        acc      <= P_W'(1);
                        idx      <= IDX_W'(P_W - 1);
                        wait_mm  <= 1'b0;
                        state    <= SQR;
                    end
                end
                SQR: begin
                    if (!wait_mm) begin
                        wait_mm <= 1'b1;
                    end else if (mm_done) begin
                        acc     <= mm_res;
                        wait_mm <= 1'b0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (!wait_mm) begin
                        wait_mm <= 1'b1;
                    end else if (mm_done) begin
                        // Multiply always runs; the exponent bit only gates the write.
                        if (priv_reg[idx]) begin
                            acc <= mm_res;
                        end
                        wait_mm <= 1'b0;
                        if (idx == '0) begin
                            state <= XOR;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SQR;
                        end
                    end
                end
                XOR: begin
                    busy      <= 1'b0;
                    done_dec2 <= 1'b1;
                    if (err_flag) begin
                        err_o <= 1'b1;
                        k_o   <= '0;
                        r2_o  <= '0;
                    end else begin
                        err_o <= 1'b0;
                        k_o   <= {{(D_W-P_W){1'b0}}, acc};
                        r2_o  <= c1_reg ^ {{(D_W-P_W){1'b0}}, acc};
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (!c1_valid_i) begin
                        done_dec2 <= 1'b0;
                        err_o     <= 1'b0;
                        k_o       <= '0;
                        r2_o      <= '0;
                        err_flag  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decryption_r2.sv
// Directed self-checking bench for decryption_r2.
module tb_decryption_r2;
    import dh_pkg::*;

    localparam int LAT_LIMIT = 3000;
    localparam logic [63:0] C1N = 64'h0123_4567_89AB_CDED;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           c1_valid_i = 1'b0;
    logic [D_W-1:0] c1 = '0;
    logic [P_W-1:0] pub = '0;
    logic [P_W-1:0] priv = '0;
    logic [P_W-1:0] p = '0;
    logic           busy;
    logic           done_dec2;
    logic           err_o;
    logic [D_W-1:0] k_o;
    logic [D_W-1:0] r2_o;

    int n_cmp = 0;
    int n_bad = 0;

    decryption_r2 dut (
        .clk        (clk),
        .rst        (rst),
        .c1_valid_i (c1_valid_i),
        .c1         (c1),
        .pub        (pub),
        .priv       (priv),
        .p          (p),
        .busy       (busy),
        .done_dec2  (done_dec2),
        .err_o      (err_o),
        .k_o        (k_o),
        .r2_o       (r2_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request and waits for done_dec2. lat = edges after the
    // acceptance edge until done is seen high. For the first tog cycles
    // c1_valid_i toggles and all operands are scrambled.
    task automatic run_req(input logic [63:0] cv, input logic [31:0] pbv,
                           input logic [31:0] pvv, input logic [31:0] ppv,
                           input bit hold, input int tog,
                           output int lat, output logic busy_acc, output logic busy_end);
        @(negedge clk);
        c1 = cv; pub = pbv; priv = pvv; p = ppv;
        c1_valid_i = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        busy_acc = busy;
        if (!hold) c1_valid_i = 1'b0;
        while (!done_dec2 && lat < LAT_LIMIT) begin
            if (lat < tog) begin
                c1_valid_i = lat[0];
                pub  = $urandom;
                priv = $urandom;
                p    = $urandom;
                c1   = {$urandom, $urandom};
            end else if (!hold) begin
                c1_valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        busy_end = busy;
    endtask

    // One edge after a pulse response: outputs must be back to zero.
    task automatic chk_cleared(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_clr"}, {63'd0, done_dec2}, 64'd0);
        chk({tag, "_r2_clr"}, r2_o, 64'd0);
    endtask

    initial begin
        int   lat;
        logic ba, be;
        int   done_cnt;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done_dec2}, 64'd0);
        chk("rst_err",  {63'd0, err_o}, 64'd0);
        chk("rst_k",    k_o, 64'd0);
        chk("rst_r2",   r2_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 19^6 mod 23 = 16^3 mod 23 = 4096 mod 23 = 2
        run_req(C1N, 32'd19, 32'd6, 32'd23, 1'b0, 0, lat, ba, be);
        chk("nom_lat", 64'(lat), 64'(DEC_LAT));
        chk("nom_busy_acc", {63'd0, ba}, 64'd1);
        chk("nom_busy_end", {63'd0, be}, 64'd0);
        chk("nom_err", {63'd0, err_o}, 64'd0);
        chk("nom_k", k_o, 64'd2);
        chk("nom_r2", r2_o, 64'h0123_4567_89AB_CDEF);
        chk_cleared("nom");

        run_req(C1N, 32'd19, 32'd0, 32'd23, 1'b0, 0, lat, ba, be);
        chk("exp0_k", k_o, 64'd1);
        chk("exp0_r2", r2_o, 64'h0123_4567_89AB_CDEC);
        chk_cleared("exp0");

        run_req(C1N, 32'd0, 32'd5, 32'd23, 1'b0, 0, lat, ba, be);
        chk("pub0_k", k_o, 64'd0);
        chk("pub0_r2", r2_o, C1N);
        chk_cleared("pub0");

        // Fermat: 2^(q-1) mod q = 1 for the prime q = 2^32-5
        run_req(C1N, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 1'b0, 0, lat, ba, be);
        chk("maxp_k", k_o, 64'd1);
        chk("maxp_r2", r2_o, 64'h0123_4567_89AB_CDEC);
        chk("maxp_lat", 64'(lat), 64'(DEC_LAT));
        chk_cleared("maxp");

        run_req(C1N, 32'd0, 32'd5, 32'd1, 1'b0, 0, lat, ba, be);
        chk("p1_lat", 64'(lat), 64'd2);
        chk("p1_busy_acc", {63'd0, ba}, 64'd1);
        chk("p1_err", {63'd0, err_o}, 64'd1);
        chk("p1_k", k_o, 64'd0);
        chk("p1_r2", r2_o, 64'd0);
        chk_cleared("p1");

        run_req(C1N, 32'd23, 32'd6, 32'd23, 1'b0, 0, lat, ba, be);
        chk("pubeq_lat", 64'(lat), 64'd2);
        chk("pubeq_err", {63'd0, err_o}, 64'd1);
        chk("pubeq_r2", r2_o, 64'd0);
        chk_cleared("pubeq");

        // Hold c1_valid_i through DONE
        run_req(C1N, 32'd19, 32'd6, 32'd23, 1'b1, 0, lat, ba, be);
        chk("hold_lat", 64'(lat), 64'(DEC_LAT));
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", {63'd0, done_dec2}, 64'd1);
        chk("hold_k", k_o, 64'd2);
        chk("hold_r2", r2_o, 64'h0123_4567_89AB_CDEF);
        c1_valid_i = 1'b0;
        chk_cleared("hold");

        // Toggling request and scrambled operands after acceptance
        run_req(C1N, 32'd19, 32'd6, 32'd23, 1'b0, 300, lat, ba, be);
        chk("tog_lat", 64'(lat), 64'(DEC_LAT));
        chk("tog_k", k_o, 64'd2);
        chk("tog_r2", r2_o, 64'h0123_4567_89AB_CDEF);
        chk_cleared("tog");

        // Reset in the middle of a run
        @(negedge clk);
        c1 = C1N; pub = 32'd19; priv = 32'd6; p = 32'd23;
        c1_valid_i = 1'b1;
        @(posedge clk);
        #1;
        c1_valid_i = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        chk("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done_dec2}, 64'd0);
        chk("arst_k", k_o, 64'd0);
        chk("arst_r2", r2_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (2300) begin
            @(posedge clk);
            #1;
            if (done_dec2) done_cnt++;
        end
        chk("arst_no_done", 64'(done_cnt), 64'd0);

        run_req(C1N, 32'd19, 32'd6, 32'd23, 1'b0, 0, lat, ba, be);
        chk("post_lat", 64'(lat), 64'(DEC_LAT));
        chk("post_k", k_o, 64'd2);
        chk("post_r2", r2_o, 64'h0123_4567_89AB_CDEF);
        chk_cleared("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
